// File: rtl/sd_read_block_dat.sv
// ============================================================================
// Module      : sd_read_block_dat
// Description : SDIO DAT-line block receiver (1/4-bit), byte stream out,
//               per-lane CRC16 and end-bit checking, multi-block with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_read_block_dat #(
   parameter int BLOCK_MAX     = 512,
   parameter int TIMEOUT_EDGES = 4096,
   localparam int LW           = $clog2(BLOCK_MAX) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          sd_clock,
   input  logic [3:0]    sd_data,
   input  logic          bus_width_4,
   input  logic          start_strobe,
   input  logic [LW-1:0] block_len,
   input  logic [8:0]    block_count,
   input  logic          abort,
   output logic          byte_strobe,
   output logic [7:0]    byte_out,
   output logic          block_done_strobe,
   output logic          block_crc_ok,
   output logic          end_bit_err,
   output logic          crc_err,
   output logic          timeout,
   output logic          all_done_strobe,
   output logic          busy
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WAIT    = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_CRC     = 3'd3;
   localparam logic [2:0] ST_END_BIT = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             s2_q, s3_q;
   logic [3:0]       d2_q;
   logic [3:0]       prev_q, prev_d;
   logic             width4_q, width4_d;
   logic [LW-1:0]    len_q, len_d;
   logic [8:0]       count_q, count_d;
   logic [8:0]       rem_q, rem_d;
   logic [LW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       crc_idx_q, crc_idx_d;
   logic [15:0]      tcnt_q, tcnt_d;
   logic [7:0]       sr_q, sr_d;
   logic [3:0][15:0] crc_q, crc_d;
   logic             ok_q, ok_d;
   logic             byte_strobe_q, byte_strobe_d;
   logic [7:0]       byte_out_q, byte_out_d;
   logic             block_done_q, block_done_d;
   logic             block_crc_ok_q, block_crc_ok_d;
   logic             end_bit_err_q, end_bit_err_d;
   logic             crc_err_q, crc_err_d;
   logic             timeout_q, timeout_d;
   logic             all_done_q, all_done_d;

   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = b ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   logic          edge_w;
   logic [3:0]    mask_w;
   logic [3:0]    lanes_w;
   logic          all1_w, all0_w, prev_all1_w;
   logic          start_bit_w, tmo_hit_w;
   logic          byte_last_w, last_byte_w, crc_last_w, end_w, more_w;
   logic [7:0]    sr_new_w;
   logic [LW-1:0] eff_len_w;

   assign edge_w      = s2_q & ~s3_q;
   assign mask_w      = width4_q ? 4'hF : 4'h1;
   assign lanes_w     = d2_q & mask_w;
   assign all1_w      = (lanes_w == mask_w);
   assign all0_w      = (lanes_w == 4'h0);
   assign prev_all1_w = ((prev_q & mask_w) == mask_w);
   assign start_bit_w = edge_w && (state_q == ST_WAIT) && all0_w && prev_all1_w;
   assign tmo_hit_w   = edge_w && (state_q == ST_WAIT) && !start_bit_w &&
                        (TIMEOUT_EDGES != 0) && ((tcnt_q + 16'd1) == 16'(TIMEOUT_EDGES));
   assign byte_last_w = width4_q ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd7);
   assign last_byte_w = edge_w && (state_q == ST_DATA) && byte_last_w && (byte_cnt_q == LW'(1));
   assign crc_last_w  = edge_w && (state_q == ST_CRC) && (crc_idx_q == 4'd15);
   assign end_w       = edge_w && (state_q == ST_END_BIT);
   assign more_w      = (count_q == 9'd0) || (rem_q != 9'd1);
   assign sr_new_w    = width4_q ? {sr_q[3:0], d2_q} : {sr_q[6:0], d2_q[0]};
   assign eff_len_w   = ((block_len == '0) || (block_len > LW'(BLOCK_MAX))) ? LW'(BLOCK_MAX) : block_len;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else if (start_strobe) begin
         state_d = ST_WAIT;
      end else begin
         case (state_q)
            ST_WAIT:    if (start_bit_w) state_d = ST_DATA;
                        else if (tmo_hit_w) state_d = ST_IDLE;
            ST_DATA:    if (last_byte_w) state_d = ST_CRC;
            ST_CRC:     if (crc_last_w) state_d = ST_END_BIT;
            ST_END_BIT: if (end_w) state_d = more_w ? ST_WAIT : ST_IDLE;
            default:    state_d = state_q;
         endcase
      end
   end

   // Datapath and registered outputs; strobes default low every cycle.
   always_comb begin
      prev_d         = prev_q;
      width4_d       = width4_q;
      len_d          = len_q;
      count_d        = count_q;
      rem_d          = rem_q;
      byte_cnt_d     = byte_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      crc_idx_d      = crc_idx_q;
      tcnt_d         = tcnt_q;
      sr_d           = sr_q;
      crc_d          = crc_q;
      ok_d           = ok_q;
      byte_strobe_d  = 1'b0;
      byte_out_d     = byte_out_q;
      block_done_d   = 1'b0;
      block_crc_ok_d = block_crc_ok_q;
      end_bit_err_d  = end_bit_err_q;
      crc_err_d      = crc_err_q;
      timeout_d      = timeout_q;
      all_done_d     = 1'b0;
      if (abort) begin
         prev_d = prev_q;
      end else if (start_strobe) begin
         width4_d      = bus_width_4;
         len_d         = eff_len_w;
         count_d       = block_count;
         rem_d         = block_count;
         end_bit_err_d = 1'b0;
         crc_err_d     = 1'b0;
         timeout_d     = 1'b0;
         crc_d         = '0;
         prev_d        = 4'hF;
         tcnt_d        = 16'd0;
      end else if (edge_w) begin
         case (state_q)
            ST_WAIT: begin
               prev_d = d2_q;
               if (TIMEOUT_EDGES != 0) tcnt_d = tcnt_q + 16'd1;
               if (start_bit_w) begin
                  byte_cnt_d = len_q;
                  bit_cnt_d  = 3'd0;
                  ok_d       = 1'b1;
               end
               if (tmo_hit_w) timeout_d = 1'b1;
            end
            ST_DATA: begin
               sr_d = sr_new_w;
               for (int i = 0; i < 4; i++) begin
                  if (mask_w[i]) crc_d[i] = crc16_step(crc_q[i], d2_q[i]);
               end
               if (byte_last_w) begin
                  bit_cnt_d     = 3'd0;
                  byte_out_d    = sr_new_w;
                  byte_strobe_d = 1'b1;
                  byte_cnt_d    = byte_cnt_q - LW'(1);
                  crc_idx_d     = 4'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            ST_CRC: begin
               for (int i = 0; i < 4; i++) begin
                  if (mask_w[i] && (d2_q[i] != crc_q[i][4'd15 - crc_idx_q])) ok_d = 1'b0;
               end
               crc_idx_d = crc_idx_q + 4'd1;
            end
            ST_END_BIT: begin
               if (!all1_w) end_bit_err_d = 1'b1;
               block_done_d   = 1'b1;
               block_crc_ok_d = ok_q;
               if (!ok_q) crc_err_d = 1'b1;
               if (count_q != 9'd0) rem_d = rem_q - 9'd1;
               if (more_w) begin
                  crc_d  = '0;
                  prev_d = 4'hF;
                  tcnt_d = 16'd0;
               end else begin
                  all_done_d = 1'b1;
               end
            end
            default: prev_d = prev_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s2_q           <= 1'b0;
         s3_q           <= 1'b0;
         d2_q           <= 4'h0;
         prev_q         <= 4'hF;
         width4_q       <= 1'b0;
         len_q          <= '0;
         count_q        <= 9'd0;
         rem_q          <= 9'd0;
         byte_cnt_q     <= '0;
         bit_cnt_q      <= 3'd0;
         crc_idx_q      <= 4'd0;
         tcnt_q         <= 16'd0;
         sr_q           <= 8'h00;
         crc_q          <= '0;
         ok_q           <= 1'b0;
         byte_strobe_q  <= 1'b0;
         byte_out_q     <= 8'h00;
         block_done_q   <= 1'b0;
         block_crc_ok_q <= 1'b0;
         end_bit_err_q  <= 1'b0;
         crc_err_q      <= 1'b0;
         timeout_q      <= 1'b0;
         all_done_q     <= 1'b0;
      end else begin
         s2_q           <= sd_clock;
         s3_q           <= s2_q;
         d2_q           <= sd_data;
         prev_q         <= prev_d;
         width4_q       <= width4_d;
         len_q          <= len_d;
         count_q        <= count_d;
         rem_q          <= rem_d;
         byte_cnt_q     <= byte_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         crc_idx_q      <= crc_idx_d;
         tcnt_q         <= tcnt_d;
         sr_q           <= sr_d;
         crc_q          <= crc_d;
         ok_q           <= ok_d;
         byte_strobe_q  <= byte_strobe_d;
         byte_out_q     <= byte_out_d;
         block_done_q   <= block_done_d;
         block_crc_ok_q <= block_crc_ok_d;
         end_bit_err_q  <= end_bit_err_d;
         crc_err_q      <= crc_err_d;
         timeout_q      <= timeout_d;
         all_done_q     <= all_done_d;
      end
   end

   assign byte_strobe       = byte_strobe_q;
   assign byte_out          = byte_out_q;
   assign block_done_strobe = block_done_q;
   assign block_crc_ok      = block_crc_ok_q;
   assign end_bit_err       = end_bit_err_q;
   assign crc_err           = crc_err_q;
   assign timeout           = timeout_q;
   assign all_done_strobe   = all_done_q;
   assign busy              = (state_q != ST_IDLE);

endmodule

`default_nettype wire
